unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants one access at a time, holds address and data stable toward the memory, and waits for the memory's ready.
- Returns read data and a one-cycle done pulse to the winning requester, and drives stall levels that the pipeline uses to freeze the PC and pipeline registers.
- Data requests have priority. A starvation counter guarantees forward progress of instruction fetch. A timeout aborts hung accesses.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before IF is forced a grant; range 1..15.
- TIMEOUT, 64: maximum cycles spent waiting for ram_ready before the access aborts; range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  instruction fetch request; held high until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for the IF port
- if_stall  out  1  if_req & ~if_done
- dm_req  in  1  data request (mem_read | mem_write); held high until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid while dm_done=1
- dm_done  out  1  one-cycle completion pulse for the data port
- dm_stall  out  1  dm_req & ~dm_done
- ram_en  out  1  memory access active
- ram_we  out  1  write strobe; only ever high together with ram_en
- ram_addr  out  32  latched address
- ram_wdata  out  32  latched write data
- ram_rdata  in  32  memory read data, valid when ram_ready=1
- ram_ready  in  1  memory completes the current access this cycle
- err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; if_rdata=0, dm_rdata=0; if_done=0, dm_done=0; err=0; starve_cnt=0; wait_cnt=0.
- Reset mid-access: ram_en and ram_we drop immediately, with no clock edge required. Any pending done pulse is lost.
- States:
  - IDLE: no access in flight.
  - DACC: data access in flight.
  - IACC: instruction access in flight.
  - DONE: one-cycle completion state.
- IDLE arbitration, evaluated at the rising edge:
  - If dm_req=1 and if_req=1 and starve_cnt == STARVE_LIMIT: grant IF.
  - Otherwise, if dm_req=1: grant data.
  - Otherwise, if if_req=1: grant IF.
  - Otherwise, stay in IDLE.
- Grant action: the grant edge registers ram_addr, ram_wdata and ram_we (dm_we for a data grant, 0 for an IF grant), sets ram_en=1 and clears wait_cnt.
- Starvation counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Clears when the arbiter is in IDLE and if_req=0.
- DACC/IACC: ram_* outputs stay constant. Each cycle with ram_ready=0 increments wait_cnt.
- Normal completion: at an edge where ram_ready=1:
  - Capture ram_rdata into the granted port's rdata register, and only that register.
  - Drop ram_en and ram_we.
  - Go to DONE with the granted port's done flag set.
- Timeout: at an edge where ram_ready=0 and wait_cnt == TIMEOUT-1:
  - Abort: drop ram_en and ram_we.
  - Set rdata to 32'h0000_0000 and set err=1.
  - Go to DONE.
- DONE lasts exactly one cycle: the granted port's done=1 and no new grant is made. It then returns to IDLE. This guarantees the requester has deasserted or changed its request before the next arbitration.
- Latency: request high at edge N gives grant at edge N. If ram_ready=1 in the first access cycle, done is high during the cycle after edge N+1. That is 2 cycles minimum from grant to done; back-to-back accesses take 3 cycles each.
- Port data hold: rdata registers hold their value until the next completion for that port.
- Request protocol:
  - Requests dropped mid-access are a protocol violation. The access still completes and the done pulse is still issued.
  - A port's address and data inputs are ignored after its grant.
- err is sticky and clears only on reset. The block keeps operating after an error.
- ram_ready while in IDLE or DONE is ignored.

Test Plan:
- Single load: dm_req=1, dm_we=0, dm_addr=0x40, ram_ready=1 in the first DACC cycle with ram_rdata=0x1234ABCD -> ram_en high for 1 cycle with ram_addr=0x40, then dm_done pulse with dm_rdata=0x1234ABCD; if_* outputs unchanged.
- Simultaneous requests: if_req=1 (addr 0x0) and dm_req=1 (addr 0x80, store 0xCAFEF00D), ram_ready tied 1 -> data granted first (ram_we=1, ram_wdata=0xCAFEF00D), dm_done pulses, then IF granted 3 cycles later.
- Starvation, STARVE_LIMIT=4: if_req held and dm_req re-issued after every dm_done -> exactly 4 data grants, then an IF grant, then data resumes.
- Timeout, TIMEOUT=64: data load with ram_ready held 0 -> ram_en deasserts after 64 access cycles; dm_done pulses with dm_rdata=0; err=1 and remains 1 through later successful accesses.
- Reset mid-access: assert reset asynchronously during IACC with ram_ready=0 -> ram_en=0 before the next edge; no if_done pulse; after release, a fresh if_req is granted at the first edge.
- Stall levels: if_req=1 with a 3-cycle ram_ready delay -> if_stall=1 every cycle until the if_done cycle; if_stall=0 in the done cycle.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch
// and the load/store stage. Data accesses win arbitration unless fetch has been
// passed over STARVE_LIMIT times in a row. Accesses that never see ram_ready
// are aborted after TIMEOUT cycles and raise a sticky error flag.
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    // data port
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    // memory side
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    // status
    output logic        err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_grant_dm;
    logic       w_grant_if;
    logic       w_finish;
    logic       w_abort;
    logic [3:0] r_starve_cnt;
    logic [7:0] r_wait_cnt;

    // Stall levels are purely combinational so the pipeline frees up in the done cycle itself.
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    // Next-state logic: arbitration in IDLE, completion/abort during an access, DONE always lasts one cycle.
    always_comb begin
        w_next     = r_state;
        w_grant_dm = 1'b0;
        w_grant_if = 1'b0;
        w_finish   = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req && if_req && (r_starve_cnt == STARVE_MAX)) begin
                    w_grant_if = 1'b1;
                    w_next     = IACC;
                end else if (dm_req) begin
                    w_grant_dm = 1'b1;
                    w_next     = DACC;
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                    w_next     = IACC;
                end
            end
            DACC, IACC: begin
                if (ram_ready) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory-side latches, read-data capture, done pulses, wait counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 32'h0;
            ram_wdata  <= 32'h0;
            if_rdata   <= 32'h0;
            dm_rdata   <= 32'h0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            err        <= 1'b0;
            r_wait_cnt <= 8'h0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (w_grant_dm) begin
                ram_en     <= 1'b1;
                ram_we     <= dm_we;
                ram_addr   <= dm_addr;
                ram_wdata  <= dm_wdata;
                r_wait_cnt <= 8'h0;
            end else if (w_grant_if) begin
                ram_en     <= 1'b1;
                ram_we     <= 1'b0;
                ram_addr   <= if_addr;
                ram_wdata  <= 32'h0;
                r_wait_cnt <= 8'h0;
            end else if (w_finish || w_abort) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                if (r_state == IACC) begin
                    if_rdata <= w_finish ? ram_rdata : 32'h0;
                    if_done  <= 1'b1;
                end else begin
                    dm_rdata <= w_finish ? ram_rdata : 32'h0;
                    dm_done  <= 1'b1;
                end
                if (w_abort) begin
                    err <= 1'b1;
                end
            end else if ((r_state == DACC) || (r_state == IACC)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'h0;
        end else if (w_grant_if) begin
            r_starve_cnt <= 4'h0;
        end else if (w_grant_dm && if_req) begin
            if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if ((r_state == IDLE) && !if_req) begin
            r_starve_cnt <= 4'h0;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table-driven single accesses, hand-written multi-cycle
// sequences (priority, starvation, timeout, reset mid-access) and a randomized
// run checked against a memory/arbitration reference model.
module tb_unified_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        err;

    unified_mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .dm_stall (dm_stall),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ready(ram_ready),
        .err      (err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        expWe;
        logic [31:0] expRdata;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expIfRd;
    logic [31:0] expDmRd;
    logic        expErr;

    // Reference memory contents: ramMem is what the memory holds, refMem what the requester expects.
    logic [31:0] ramMem [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];

    int          cycles;
    int          grantKinds[$];
    bit          prevEn;
    bit          ifPend;
    bit          dmPend;
    bit          drvIf;
    bit          drvDm;
    bit          dmWeR;
    bit          expIfWin;
    bit          abortRnd;
    logic [31:0] ifA;
    logic [31:0] dmA;
    logic [31:0] dmWdR;
    int          ifAge;
    int          dmAge;
    int          starve;
    int          waitRun;

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        return ramMem.exists(a) ? ramMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access from an idle arbiter: request, grant, ready delay, done pulse, release.
    task automatic applyStimulus(input vec_t v, input int idx);
        ram_ready = 1'b0;
        ram_rdata = 32'h5A5A_5A5A;
        if (v.isData) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        #1;
        checkBit($sformatf("vec%0d stall before grant", idx), v.isData ? dm_stall : if_stall, 1'b1);
        tick;
        checkBit($sformatf("vec%0d ram_en at grant", idx), ram_en, 1'b1);
        checkOutput($sformatf("vec%0d ram_addr", idx), ram_addr, v.addr);
        checkBit($sformatf("vec%0d ram_we", idx), ram_we, v.expWe);
        if (v.isData && v.we) begin
            checkOutput($sformatf("vec%0d ram_wdata", idx), ram_wdata, v.wdata);
        end
        for (int k = 0; k <= v.delay; k++) begin
            ram_ready = (k == v.delay);
            ram_rdata = ram_ready ? v.rdata : 32'h5A5A_5A5A;
            #1;
            checkBit($sformatf("vec%0d stall while waiting", idx), v.isData ? dm_stall : if_stall, 1'b1);
            tick;
            if (k < v.delay) begin
                checkBit($sformatf("vec%0d ram_en held", idx), ram_en, 1'b1);
                checkBit($sformatf("vec%0d no early done", idx), if_done | dm_done, 1'b0);
            end
        end
        if (v.isData) begin
            expDmRd = v.expRdata;
        end else begin
            expIfRd = v.expRdata;
        end
        checkOutput($sformatf("vec%0d done flags", idx), {30'h0, if_done, dm_done},
                    v.isData ? 32'h1 : 32'h2);
        checkOutput($sformatf("vec%0d dm_rdata", idx), dm_rdata, expDmRd);
        checkOutput($sformatf("vec%0d if_rdata", idx), if_rdata, expIfRd);
        checkBit($sformatf("vec%0d ram_en dropped", idx), ram_en, 1'b0);
        checkBit($sformatf("vec%0d stall in done cycle", idx), v.isData ? dm_stall : if_stall, 1'b0);
        checkBit($sformatf("vec%0d err", idx), err, expErr);
        dm_req    = 1'b0;
        if_req    = 1'b0;
        ram_ready = 1'b0;
        tick;
        checkBit($sformatf("vec%0d done is one cycle", idx), if_done | dm_done, 1'b0);
    endtask

    // Watchdog so the bench always ends even if the main sequence hangs.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_ABCD, 0, 1'b0, 32'h1234_ABCD};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1, 1'b1, 32'h0BAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0013, 3, 1'b0, 32'h0000_0013};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 2, 1'b0, 32'hFFFF_FFFF};

        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        ram_rdata = 32'h0;
        ram_ready = 1'b0;
        expIfRd   = 32'h0;
        expDmRd   = 32'h0;
        expErr    = 1'b0;
        tick;
        tick;
        checkBit("reset ram_en", ram_en, 1'b0);
        checkBit("reset ram_we", ram_we, 1'b0);
        checkOutput("reset ram_addr", ram_addr, 32'h0);
        checkOutput("reset ram_wdata", ram_wdata, 32'h0);
        checkOutput("reset if_rdata", if_rdata, 32'h0);
        checkOutput("reset dm_rdata", dm_rdata, 32'h0);
        checkOutput("reset done/err", {29'h0, if_done, dm_done, err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] table-driven single accesses");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] simultaneous requests");
        if_req    = 1'b1;
        if_addr   = 32'h0;
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        dm_addr   = 32'h80;
        dm_wdata  = 32'hCAFE_F00D;
        ram_ready = 1'b1;
        ram_rdata = 32'h1111_1111;
        tick;
        checkOutput("simul data wins addr", ram_addr, 32'h80);
        checkBit("simul data wins we", ram_we, 1'b1);
        checkOutput("simul wdata", ram_wdata, 32'hCAFE_F00D);
        tick;
        checkOutput("simul dm done first", {30'h0, if_done, dm_done}, 32'h1);
        checkBit("simul if stalled", if_stall, 1'b1);
        dm_req = 1'b0;
        tick;
        checkBit("simul no grant in done", ram_en, 1'b0);
        tick;
        checkBit("simul if granted", ram_en, 1'b1);
        checkOutput("simul if addr", ram_addr, 32'h0);
        checkBit("simul if we", ram_we, 1'b0);
        tick;
        checkBit("simul if done", if_done, 1'b1);
        checkOutput("simul if rdata", if_rdata, 32'h1111_1111);
        expIfRd = 32'h1111_1111;
        expDmRd = 32'h1111_1111;
        if_req    = 1'b0;
        ram_ready = 1'b0;
        tick;

        $display("[TB] starvation sequence");
        if_req    = 1'b1;
        if_addr   = 32'h200;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h100;
        ram_ready = 1'b1;
        ram_rdata = 32'h2222_2222;
        prevEn    = ram_en;
        for (int c = 0; c < 60 && grantKinds.size() < 6; c++) begin
            tick;
            if (ram_en && !prevEn) begin
                grantKinds.push_back((ram_addr == 32'h200) ? 1 : 0);
            end
            if (if_done) begin
                if_req = 1'b0;
            end
            prevEn = ram_en;
        end
        checkOutput("starve grant count", grantKinds.size(), 6);
        for (int g = 0; g < 6; g++) begin
            checkOutput($sformatf("starve grant %0d is IF", g),
                        (g < grantKinds.size()) ? grantKinds[g] : -1, (g == 4) ? 1 : 0);
        end
        tick;
        checkBit("starve final dm done", dm_done, 1'b1);
        dm_req    = 1'b0;
        if_req    = 1'b0;
        ram_ready = 1'b0;
        expIfRd   = 32'h2222_2222;
        expDmRd   = 32'h2222_2222;
        tick;

        $display("[TB] timeout sequence");
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h44;
        ram_ready = 1'b0;
        ram_rdata = 32'hFFFF_FFFF;
        tick;
        checkBit("timeout grant", ram_en, 1'b1);
        cycles = 1;
        for (int i = 0; i < 100 && ram_en; i++) begin
            tick;
            if (ram_en) cycles++;
        end
        checkOutput("timeout access cycles", cycles, TIMEOUT);
        checkBit("timeout dm_done", dm_done, 1'b1);
        checkOutput("timeout dm_rdata", dm_rdata, 32'h0);
        checkBit("timeout err set", err, 1'b1);
        dm_req = 1'b0;
        tick;
        checkBit("timeout done one cycle", dm_done, 1'b0);
        expDmRd = 32'h0;
        expErr  = 1'b1;
        applyStimulus(vecs[0], 5);
        checkBit("err sticky after access", err, 1'b1);

        $display("[TB] reset mid-access");
        if_req    = 1'b1;
        if_addr   = 32'h300;
        ram_ready = 1'b0;
        tick;
        checkBit("rst-mid grant", ram_en, 1'b1);
        tick;
        tick;
        #2;
        reset = 1'b1;
        #1;
        checkBit("rst-mid ram_en async", ram_en, 1'b0);
        checkBit("rst-mid ram_we async", ram_we, 1'b0);
        checkBit("rst-mid no if_done", if_done, 1'b0);
        checkBit("rst-mid err cleared", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        checkBit("rst-mid regrant", ram_en, 1'b1);
        checkOutput("rst-mid regrant addr", ram_addr, 32'h300);
        checkBit("rst-mid still no done", if_done, 1'b0);
        ram_ready = 1'b1;
        ram_rdata = 32'h0000_0073;
        tick;
        checkBit("rst-mid if_done", if_done, 1'b1);
        checkOutput("rst-mid if_rdata", if_rdata, 32'h0000_0073);
        if_req    = 1'b0;
        ram_ready = 1'b0;
        tick;

        $display("[TB] randomized traffic");
        ifPend   = 1'b0;
        dmPend   = 1'b0;
        dmWeR    = 1'b0;
        ifA      = 32'h0;
        dmA      = 32'h100;
        dmWdR    = 32'h0;
        ifAge    = 0;
        dmAge    = 0;
        starve   = 0;
        waitRun  = 0;
        abortRnd = 1'b0;
        prevEn   = ram_en;
        for (int cyc = 0; cyc < 3000 && !abortRnd; cyc++) begin
            if (!ifPend && ($urandom_range(0, 3) == 0)) begin
                ifPend = 1'b1;
                ifA    = $urandom_range(0, 63) << 2;
                ifAge  = 0;
            end
            if (!dmPend && ($urandom_range(0, 2) == 0)) begin
                dmPend = 1'b1;
                dmWeR  = 1'($urandom_range(0, 1));
                dmA    = 32'h100 + ($urandom_range(0, 15) << 2);
                dmWdR  = $urandom;
                dmAge  = 0;
            end
            if_req   = ifPend;
            if_addr  = ifA;
            dm_req   = dmPend;
            dm_we    = dmWeR;
            dm_addr  = dmA;
            dm_wdata = dmWdR;
            if (ram_en) begin
                ram_ready = (waitRun >= 3) || ($urandom_range(0, 2) == 0);
                if (ram_ready) begin
                    ram_rdata = ramRead(ram_addr);
                    if (ram_we) ramMem[ram_addr] = ram_wdata;
                    waitRun = 0;
                end else begin
                    ram_rdata = $urandom;
                    waitRun++;
                end
            end else begin
                ram_ready = 1'($urandom_range(0, 1));
                ram_rdata = $urandom;
                waitRun   = 0;
            end
            drvIf = ifPend;
            drvDm = dmPend;
            tick;

            checkBit("rnd ram_we only with ram_en", ram_we & ~ram_en, 1'b0);
            checkBit("rnd single done", if_done & dm_done, 1'b0);
            if (ram_en && !prevEn) begin
                checkBit("rnd grant has request", drvIf | drvDm, 1'b1);
                expIfWin = drvIf && (!drvDm || (starve == STARVE_LIMIT));
                if (expIfWin) begin
                    checkOutput("rnd IF grant addr", ram_addr, ifA);
                    checkBit("rnd IF grant we", ram_we, 1'b0);
                    starve = 0;
                end else begin
                    checkOutput("rnd data grant addr", ram_addr, dmA);
                    checkBit("rnd data grant we", ram_we, dmWeR);
                    checkOutput("rnd data grant wdata", ram_wdata, dmWdR);
                    starve = drvIf ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
                end
            end
            prevEn = ram_en;
            if (dm_done) begin
                checkBit("rnd dm_done has request", dmPend, 1'b1);
                if (dmWeR) begin
                    refMem[dmA] = dmWdR;
                end else begin
                    checkOutput("rnd load data", dm_rdata, refRead(dmA));
                end
                dmPend = 1'b0;
            end
            if (if_done) begin
                checkBit("rnd if_done has request", ifPend, 1'b1);
                checkOutput("rnd fetch data", if_rdata, initVal(ifA));
                ifPend = 1'b0;
            end
            if (ifPend) ifAge++;
            if (dmPend) dmAge++;
            if ((ifAge > 200) || (dmAge > 200)) begin
                checks++;
                errors++;
                $display("[TB] FAIL rnd request completion: if age %0d, dm age %0d, limit 200", ifAge, dmAge);
                abortRnd = 1'b1;
            end
        end
        checkBit("rnd err stays clear", err, 1'b0);
        if_req    = 1'b0;
        dm_req    = 1'b0;
        ram_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
